// File: rtl/cell_chain_pkg.sv
// Shared types and limits for the cell_chain two-phase toggle counter.
// Phase FSM encoding plus the largest supported stage count.
package cell_chain_pkg;

    typedef enum logic {
        PH_IDLE  = 1'b0,
        PH_ARMED = 1'b1
    } phase_t;

    localparam int CC_MAX_WIDTH = 17;

endpackage

// File: rtl/cell_chain_latch.sv
// Master latch bank and phase FSM: captures chain inputs on enp, arms the slave update.
// Latency: latches valid the clk after enp; update strobe is combinational on enn while ARMED.
// Backpressure: none; enn without a prior enp is dropped (CELL_CHAIN_UPDOWN_EN adds dir).
module cell_chain_latch
    import cell_chain_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enp_i,
    input  logic             enn_i,
    input  logic             t_in_i,
    input  logic             r_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
`ifdef CELL_CHAIN_UPDOWN_EN
    input  logic             dir_i,
    output logic             dir_l_o,
`endif
    output logic             t_in_l_o,
    output logic             r_l_o,
    output logic             ld_l_o,
    output logic [WIDTH-1:0] d_l_o,
    output logic             upd_o
);

    phase_t           state_q, state_d;
    logic             t_in_q, r_q, ld_q;
    logic [WIDTH-1:0] d_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // enp wins over enn so a coincident pair leaves the cell ARMED.
    always_comb begin
        state_d = state_q;
        if (enp_i) begin
            state_d = PH_ARMED;
        end else if (enn_i && (state_q == PH_ARMED)) begin
            state_d = PH_IDLE;
        end
    end

    always_comb begin
        upd_o = enn_i && (state_q == PH_ARMED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_in_q <= 1'b0;
            r_q    <= 1'b0;
            ld_q   <= 1'b0;
            d_q    <= '0;
        end else if (enp_i) begin
            t_in_q <= t_in_i;
            r_q    <= r_i;
            ld_q   <= ld_i;
            d_q    <= d_i;
        end
    end

`ifdef CELL_CHAIN_UPDOWN_EN
    logic dir_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_q <= 1'b0;
        end else if (enp_i) begin
            dir_q <= dir_i;
        end
    end

    assign dir_l_o = dir_q;
`endif

    assign t_in_l_o = t_in_q;
    assign r_l_o    = r_q;
    assign ld_l_o   = ld_q;
    assign d_l_o    = d_q;

endmodule

// File: rtl/cell_chain.sv
// WIDTH-stage two-phase toggle counter with clear, load, terminal count and carry out.
// Latency: q changes on the enn edge after the enp sample; t_out is combinational.
// Backpressure: none; CELL_CHAIN_UPDOWN_EN adds dir for down-count and borrow chaining.
module cell_chain
    import cell_chain_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enp,
    input  logic             enn,
    input  logic             t_in,
    input  logic             r,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
`ifdef CELL_CHAIN_UPDOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic             t_out,
    output logic             nt_out,
    output logic             tc
);

    generate
        if ((WIDTH < 1) || (WIDTH > CC_MAX_WIDTH)) begin : g_bad_width
            $error("cell_chain: WIDTH out of range 1..17");
        end
    endgenerate

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             t_in_l, r_l, ld_l, upd;
    logic [WIDTH-1:0] d_l;
    logic [WIDTH-1:0] q_q, q_d;

`ifdef CELL_CHAIN_UPDOWN_EN
    logic dir_l;
`endif

    cell_chain_latch #(
        .WIDTH (WIDTH)
    ) u_latch (
        .clk      (clk),
        .reset_n  (reset_n),
        .enp_i    (enp),
        .enn_i    (enn),
        .t_in_i   (t_in),
        .r_i      (r),
        .ld_i     (ld),
        .d_i      (d),
`ifdef CELL_CHAIN_UPDOWN_EN
        .dir_i    (dir),
        .dir_l_o  (dir_l),
`endif
        .t_in_l_o (t_in_l),
        .r_l_o    (r_l),
        .ld_l_o   (ld_l),
        .d_l_o    (d_l),
        .upd_o    (upd)
    );

    // Slave stage: reads the pre-edge latch values, so a coincident enp/enn uses old samples.
    always_comb begin
        q_d = q_q;
        if (upd) begin
            if (r_l) begin
                q_d = RST_VAL;
            end else if (ld_l) begin
                q_d = d_l;
            end else if (t_in_l) begin
`ifdef CELL_CHAIN_UPDOWN_EN
                q_d = dir_l ? (q_q - ONE) : (q_q + ONE);
`else
                q_d = q_q + ONE;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

`ifdef CELL_CHAIN_UPDOWN_EN
    assign tc = dir_l ? (q_q == '0) : (&q_q);
`else
    assign tc = &q_q;
`endif

    assign q      = q_q;
    assign nq     = ~q_q;
    assign t_out  = t_in_l & tc;
    assign nt_out = ~t_out;

endmodule

// File: tb/tb_cell_chain.sv
// Directed self-checking bench for cell_chain (WIDTH=4, RST_VAL=0).
// CELL_CHAIN_UPDOWN_EN adds down-count and cascaded borrow scenarios.
module tb_cell_chain;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enp = 1'b0;
    logic       enn = 1'b0;
    logic       t_in = 1'b0;
    logic       r = 1'b0;
    logic       ld = 1'b0;
    logic [3:0] d = 4'h0;
    logic [3:0] q, nq;
    logic       t_out, nt_out, tc;

    int n_cmp = 0;
    int n_err = 0;

    always #10 clk = ~clk;

`ifdef CELL_CHAIN_UPDOWN_EN
    logic       dir = 1'b0;
    logic       hi_ld = 1'b0;
    logic [3:0] hi_d = 4'h0;
    logic [3:0] hi_q, hi_nq;
    logic       hi_t_out, hi_nt_out, hi_tc;
`endif

    cell_chain #(.WIDTH(4), .RST_VAL(4'h0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enp     (enp),
        .enn     (enn),
        .t_in    (t_in),
        .r       (r),
        .ld      (ld),
        .d       (d),
`ifdef CELL_CHAIN_UPDOWN_EN
        .dir     (dir),
`endif
        .q       (q),
        .nq      (nq),
        .t_out   (t_out),
        .nt_out  (nt_out),
        .tc      (tc)
    );

`ifdef CELL_CHAIN_UPDOWN_EN
    cell_chain #(.WIDTH(4), .RST_VAL(4'h0)) dut_hi (
        .clk     (clk),
        .reset_n (reset_n),
        .enp     (enp),
        .enn     (enn),
        .t_in    (t_out),
        .r       (1'b0),
        .ld      (hi_ld),
        .d       (hi_d),
        .dir     (dir),
        .q       (hi_q),
        .nq      (hi_nq),
        .t_out   (hi_t_out),
        .nt_out  (hi_nt_out),
        .tc      (hi_tc)
    );
`endif

    task automatic pulse_enp();
        @(negedge clk); enp = 1'b1;
        @(negedge clk); enp = 1'b0;
    endtask

    task automatic pulse_enn();
        @(negedge clk); enn = 1'b1;
        @(negedge clk); enn = 1'b0;
    endtask

    task automatic pulse_pair();
        pulse_enp();
        pulse_enn();
    endtask

    task automatic pulse_both();
        @(negedge clk); enp = 1'b1; enn = 1'b1;
        @(negedge clk); enp = 1'b0; enn = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #5;
        n_cmp++;
        if (q !== 4'h0 || nq !== 4'hF) begin
            n_err++; $display("FAIL reset_q: q=%h nq=%h required q=0 nq=f", q, nq);
        end
        n_cmp++;
        if (t_out !== 1'b0 || nt_out !== 1'b1 || tc !== 1'b0) begin
            n_err++; $display("FAIL reset_carry: t_out=%b nt_out=%b tc=%b required 0 1 0", t_out, nt_out, tc);
        end
        @(negedge clk); reset_n = 1'b1;
        t_in = 1'b1;
        repeat (3) pulse_pair();
        n_cmp++;
        if (q !== 4'h3) begin
            n_err++; $display("FAIL count3: q=%h required 3", q);
        end
        r = 1'b1;
        pulse_enp();
        r = 1'b0;
        n_cmp++;
        if (q !== 4'h3) begin
            n_err++; $display("FAIL clear_waits_enn: q=%h required 3", q);
        end
        pulse_enn();
        n_cmp++;
        if (q !== 4'h0) begin
            n_err++; $display("FAIL clear: q=%h required 0", q);
        end
    endtask

    task automatic test_wrap();
        t_in = 1'b1;
        repeat (15) pulse_pair();
        n_cmp++;
        if (q !== 4'hF || tc !== 1'b1 || t_out !== 1'b1 || nt_out !== 1'b0) begin
            n_err++; $display("FAIL wrap_tc: q=%h tc=%b t_out=%b nt_out=%b required f 1 1 0", q, tc, t_out, nt_out);
        end
        pulse_pair();
        n_cmp++;
        if (q !== 4'h0 || tc !== 1'b0 || t_out !== 1'b0) begin
            n_err++; $display("FAIL wrap_zero: q=%h tc=%b t_out=%b required 0 0 0", q, tc, t_out);
        end
    endtask

    task automatic test_load();
        t_in = 1'b0; ld = 1'b1; d = 4'hA;
        pulse_pair();
        n_cmp++;
        if (q !== 4'hA || nq !== 4'h5) begin
            n_err++; $display("FAIL load: q=%h nq=%h required a 5", q, nq);
        end
        r = 1'b1; t_in = 1'b1;
        pulse_pair();
        n_cmp++;
        if (q !== 4'h0) begin
            n_err++; $display("FAIL clear_priority: q=%h required 0", q);
        end
        r = 1'b0; d = 4'h5;
        pulse_pair();
        n_cmp++;
        if (q !== 4'h5) begin
            n_err++; $display("FAIL load_over_toggle: q=%h required 5", q);
        end
        ld = 1'b0; t_in = 1'b0;
        pulse_pair();
        n_cmp++;
        if (q !== 4'h5) begin
            n_err++; $display("FAIL hold: q=%h required 5", q);
        end
    endtask

    task automatic test_phase_guard();
        t_in = 1'b1;
        pulse_enn();
        n_cmp++;
        if (q !== 4'h5) begin
            n_err++; $display("FAIL enn_idle: q=%h required 5", q);
        end
        pulse_enp();
        t_in = 1'b0;
        pulse_enp();
        pulse_enn();
        n_cmp++;
        if (q !== 4'h5) begin
            n_err++; $display("FAIL last_enp_wins: q=%h required 5", q);
        end
        t_in = 1'b1;
        pulse_enp();
        t_in = 1'b0;
        pulse_both();
        n_cmp++;
        if (q !== 4'h6) begin
            n_err++; $display("FAIL both_old_latch: q=%h required 6", q);
        end
        t_in = 1'b1;
        pulse_enn();
        n_cmp++;
        if (q !== 4'h6) begin
            n_err++; $display("FAIL both_new_latch: q=%h required 6", q);
        end
        pulse_enn();
        n_cmp++;
        if (q !== 4'h6) begin
            n_err++; $display("FAIL both_then_idle: q=%h required 6", q);
        end
    endtask

    task automatic test_async_reset();
        t_in = 1'b1;
        pulse_enp();
        #3 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (q !== 4'h0 || t_out !== 1'b0) begin
            n_err++; $display("FAIL async_reset: q=%h t_out=%b required 0 0", q, t_out);
        end
        @(negedge clk); reset_n = 1'b1;
        pulse_enn();
        n_cmp++;
        if (q !== 4'h0) begin
            n_err++; $display("FAIL aborted_update: q=%h required 0", q);
        end
    endtask

`ifdef CELL_CHAIN_UPDOWN_EN
    task automatic test_updown();
        dir = 1'b1; t_in = 1'b1;
        pulse_pair();
        n_cmp++;
        if (q !== 4'hF || tc !== 1'b0) begin
            n_err++; $display("FAIL down_wrap: q=%h tc=%b required f 0", q, tc);
        end
        dir = 1'b0; t_in = 1'b0;
        pulse_enp();
        n_cmp++;
        if (tc !== 1'b1) begin
            n_err++; $display("FAIL up_tc_after_dir: tc=%b required 1", tc);
        end
        pulse_enn();
    endtask

    task automatic test_cascade();
        dir = 1'b1; t_in = 1'b1;
        ld = 1'b1; d = 4'h0;
        hi_ld = 1'b1; hi_d = 4'h1;
        pulse_pair();
        n_cmp++;
        if ({hi_q, q} !== 8'h10 || t_out !== 1'b1) begin
            n_err++; $display("FAIL cascade_load: q=%h t_out=%b required 10 1", {hi_q, q}, t_out);
        end
        ld = 1'b0; hi_ld = 1'b0;
        pulse_pair();
        n_cmp++;
        if ({hi_q, q} !== 8'h0F) begin
            n_err++; $display("FAIL cascade_borrow: q=%h required 0f", {hi_q, q});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_wrap();
        test_load();
        test_phase_guard();
        test_async_reset();
`ifdef CELL_CHAIN_UPDOWN_EN
        test_updown();
        test_cascade();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
